regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32), writeback data width.
REQ-002 Parameter REGADDR_WIDTH, default `REGADDR_WIDTH (5), register index width; 2**REGADDR_WIDTH registers.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_rd  input  REGADDR_WIDTH  ALU destination register.
REQ-007 alu_data  input  DATA_WIDTH  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle.
REQ-009 mem_valid  input  1  load-data writeback request.
REQ-010 mem_rd  input  REGADDR_WIDTH  load destination register.
REQ-011 mem_data  input  DATA_WIDTH  load data.
REQ-012 mem_ready  output  1  load request accepted this cycle.
REQ-013 issue_valid  input  1  instruction issued with a pending register write.
REQ-014 issue_rd  input  REGADDR_WIDTH  destination of issued instruction.
REQ-015 wb_data  output  DATA_WIDTH  register-file write data.
REQ-016 wb_select  output  REGADDR_WIDTH  register-file write index.
REQ-017 wb_enable  output  1  register-file write strobe.
REQ-018 busy_mask  output  2**REGADDR_WIDTH  bit i set = write to register i pending.
REQ-019 wb_count  output  16  count of committed writes, wraps 0xFFFF->0x0000.

Function
REQ-020 Accept = valid && ready per requester; at most one accept per cycle.
REQ-021 Only alu_valid: alu_ready=1, mem_ready=0; only mem_valid: mem_ready=1, alu_ready=0; neither: both 0.
REQ-022 Both valid: grant the requester not granted last; last_grant updates only on an accept.
REQ-023 Ready outputs combinational from valids and last_grant; no dependence on ready->valid.
REQ-024 Accept at edge N drives wb_enable=1, wb_select=rd, wb_data=data for cycle N+1 (latency 1, registered outputs).
REQ-025 No accept at edge N: wb_enable=0 in cycle N+1; wb_select/wb_data hold last value.
REQ-026 Accepted request with rd=0: consumed, wb_enable=0, no busy_mask change, wb_count unchanged.
REQ-027 Back-to-back accepts every cycle: wb_enable continuously 1, one write per cycle, no bubbles.
REQ-028 issue_valid with issue_rd!=0 sets busy_mask[issue_rd] at next edge; issue_rd=0 ignored.
REQ-029 Committed write (wb_enable=1) clears busy_mask[wb_select] at the edge ending that cycle.
REQ-030 Set and clear of the same bit at one edge: set wins.
REQ-031 busy_mask[0] constant 0.
REQ-032 wb_count increments by 1 at the edge ending each cycle with wb_enable=1.

Reset
REQ-033 reset asserted: immediately wb_enable=0, wb_select=0, wb_data=0, busy_mask=0, wb_count=0, last_grant=MEM (ALU wins first tie).
REQ-034 reset mid-operation drops any registered write; no register-file write occurs while reset is high.
REQ-035 alu_ready=mem_ready=0 while reset is high.

Structure
REQ-036 DATA_WIDTH, REGADDR_WIDTH and requester encodings (GRANT_ALU=0, GRANT_MEM=1) reside in the shared global-definitions include.
REQ-037 Two-input round-robin grant logic is one sub-module, wb_rr_arbiter; scoreboard and output registers stay in the top.

Verification
REQ-038 alu_valid only, rd=5, data=0x1234 -> alu_ready=1, next cycle wb_enable=1, wb_select=5, wb_data=0x1234, wb_count=1.
REQ-039 Both valid for 4 cycles (alu rd=1, mem rd=2) after reset -> grants ALU,MEM,ALU,MEM; writes to 1,2,1,2.
REQ-040 issue rd=7, then mem write rd=7 three cycles later -> busy_mask[7]=1 then 0 after commit edge; issue rd=7 on commit cycle -> bit stays 1.
REQ-041 alu_valid with rd=0, data=0xFFFF -> alu_ready=1, wb_enable stays 0, busy_mask and wb_count unchanged.
REQ-042 reset asserted between accept and write cycle -> wb_enable=0 asynchronously, busy_mask=0, wb_count=0.
REQ-043 wb_count preloaded to 0xFFFF via 65535 writes, one more write -> wb_count=0x0000.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and requester encodings for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int WB_DATA_WIDTH    = 32;
  localparam int WB_REGADDR_WIDTH = 5;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-input round-robin grant logic; remembers which requester won the last accept.
module wb_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req_alu,
  input  logic i_req_mem,
  output logic o_gnt_alu,
  output logic o_gnt_mem
);

  grant_e r_last_grant;
  grant_e w_next_grant;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_last_grant <= GRANT_MEM;
    else         r_last_grant <= w_next_grant;
  end

  // A grant is always an accept, since grants only go to requesters that are valid.
  always_comb begin
    o_gnt_alu    = 1'b0;
    o_gnt_mem    = 1'b0;
    w_next_grant = r_last_grant;
    if (!i_reset) begin
      if (i_req_alu && (!i_req_mem || r_last_grant == GRANT_MEM)) begin
        o_gnt_alu    = 1'b1;
        w_next_grant = GRANT_ALU;
      end else if (i_req_mem) begin
        o_gnt_mem    = 1'b1;
        w_next_grant = GRANT_MEM;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks one of ALU/load results per cycle, registers the write,
// and tracks pending destination registers plus a committed-write counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int REGADDR_WIDTH = WB_REGADDR_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_alu_valid,
  input  logic [REGADDR_WIDTH-1:0]    i_alu_rd,
  input  logic [DATA_WIDTH-1:0]       i_alu_data,
  output logic                        o_alu_ready,
  input  logic                        i_mem_valid,
  input  logic [REGADDR_WIDTH-1:0]    i_mem_rd,
  input  logic [DATA_WIDTH-1:0]       i_mem_data,
  output logic                        o_mem_ready,
  input  logic                        i_issue_valid,
  input  logic [REGADDR_WIDTH-1:0]    i_issue_rd,
  output logic [DATA_WIDTH-1:0]       o_wb_data,
  output logic [REGADDR_WIDTH-1:0]    o_wb_select,
  output logic                        o_wb_enable,
  output logic [2**REGADDR_WIDTH-1:0] o_busy_mask,
  output logic [15:0]                 o_wb_count
);

  localparam int NUM_REGS = 2**REGADDR_WIDTH;

  logic                     w_gnt_alu;
  logic                     w_gnt_mem;
  logic                     w_accept;
  logic [REGADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [NUM_REGS-1:0]      w_busy_set;
  logic [NUM_REGS-1:0]      w_busy_clr;
  logic [NUM_REGS-1:0]      w_busy_next;

  logic                     r_wb_enable;
  logic [REGADDR_WIDTH-1:0] r_wb_select;
  logic [DATA_WIDTH-1:0]    r_wb_data;
  logic [NUM_REGS-1:0]      r_busy_mask;
  logic [15:0]              r_wb_count;

  wb_rr_arbiter u_arb (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req_alu (i_alu_valid),
    .i_req_mem (i_mem_valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_mem (w_gnt_mem)
  );

  assign o_alu_ready = w_gnt_alu;
  assign o_mem_ready = w_gnt_mem;
  assign w_accept    = w_gnt_alu | w_gnt_mem;
  assign w_rd        = w_gnt_alu ? i_alu_rd   : i_mem_rd;
  assign w_data      = w_gnt_alu ? i_alu_data : i_mem_data;

  // Set beats clear when issue and commit hit the same bit; x0 never goes busy.
  assign w_busy_set  = (i_issue_valid && i_issue_rd != '0) ? (NUM_REGS'(1) << i_issue_rd) : '0;
  assign w_busy_clr  = r_wb_enable ? (NUM_REGS'(1) << r_wb_select) : '0;
  assign w_busy_next = ((r_busy_mask & ~w_busy_clr) | w_busy_set) & ~NUM_REGS'(1);

  // Writes to x0 are consumed without touching the write port registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wb_enable <= 1'b0;
      r_wb_select <= '0;
      r_wb_data   <= '0;
      r_busy_mask <= '0;
      r_wb_count  <= '0;
    end else begin
      r_wb_enable <= w_accept && (w_rd != '0);
      if (w_accept && (w_rd != '0)) begin
        r_wb_select <= w_rd;
        r_wb_data   <= w_data;
      end
      r_busy_mask <= w_busy_next;
      if (r_wb_enable) r_wb_count <= r_wb_count + 16'd1;
    end
  end

  assign o_wb_enable = r_wb_enable;
  assign o_wb_select = r_wb_select;
  assign o_wb_data   = r_wb_data;
  assign o_busy_mask = r_busy_mask;
  assign o_wb_count  = r_wb_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a cycle-level reference model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        aluValid, memValid, issueValid;
  logic [4:0]  aluRd, memRd, issueRd;
  logic [31:0] aluData, memData;
  logic        aluReady, memReady, wbEnable;
  logic [31:0] wbData;
  logic [4:0]  wbSelect;
  logic [31:0] busyMask;
  logic [15:0] wbCount;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  bit          mLastMem;
  bit          mEn;
  logic [4:0]  mSel;
  logic [31:0] mData;
  logic [31:0] mBusy;
  logic [15:0] mCount;

  regfile_wb_arbiter dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_alu_valid   (aluValid),
    .i_alu_rd      (aluRd),
    .i_alu_data    (aluData),
    .o_alu_ready   (aluReady),
    .i_mem_valid   (memValid),
    .i_mem_rd      (memRd),
    .i_mem_data    (memData),
    .o_mem_ready   (memReady),
    .i_issue_valid (issueValid),
    .i_issue_rd    (issueRd),
    .o_wb_data     (wbData),
    .o_wb_select   (wbSelect),
    .o_wb_enable   (wbEnable),
    .o_busy_mask   (busyMask),
    .o_wb_count    (wbCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mLastMem = 1'b1;
    mEn      = 1'b0;
    mSel     = '0;
    mData    = '0;
    mBusy    = '0;
    mCount   = '0;
  endtask

  // Drives one cycle of requests, checks readies before the edge and registered outputs after it.
  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
                               input logic mV, input logic [4:0] mRd, input logic [31:0] mD,
                               input logic iV, input logic [4:0] iRd);
    bit expAlu, expMem;
    @(negedge clk);
    aluValid = aV; aluRd = aRd; aluData = aD;
    memValid = mV; memRd = mRd; memData = mD;
    issueValid = iV; issueRd = iRd;
    #1;
    expAlu = aV && (!mV || mLastMem);
    expMem = mV && (!aV || !mLastMem);
    checkOutput("alu_ready", {31'd0, aluReady}, {31'd0, expAlu});
    checkOutput("mem_ready", {31'd0, memReady}, {31'd0, expMem});
    if (mEn) begin
      mBusy[mSel] = 1'b0;
      mCount = mCount + 16'd1;
    end
    if (iV && iRd != 5'd0) mBusy[iRd] = 1'b1;
    mEn = 1'b0;
    if (expAlu || expMem) begin
      mLastMem = expMem;
      if ((expAlu ? aRd : mRd) != 5'd0) begin
        mEn   = 1'b1;
        mSel  = expAlu ? aRd : mRd;
        mData = expAlu ? aD : mD;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("wb_enable", {31'd0, wbEnable}, {31'd0, mEn});
    checkOutput("wb_select", {27'd0, wbSelect}, {27'd0, mSel});
    checkOutput("wb_data", wbData, mData);
    checkOutput("busy_mask", busyMask, mBusy);
    checkOutput("wb_count", {16'd0, wbCount}, {16'd0, mCount});
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    aluValid = 1'b1; memValid = 1'b1; issueValid = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_alu_ready", {31'd0, aluReady}, 32'd0);
    checkOutput("reset_mem_ready", {31'd0, memReady}, 32'd0);
    checkOutput("reset_wb_enable", {31'd0, wbEnable}, 32'd0);
    checkOutput("reset_wb_select", {27'd0, wbSelect}, 32'd0);
    checkOutput("reset_wb_data", wbData, 32'd0);
    checkOutput("reset_busy_mask", busyMask, 32'd0);
    checkOutput("reset_wb_count", {16'd0, wbCount}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    aluValid = 1'b0; memValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    aluValid = 0; memValid = 0; issueValid = 0;
    aluRd = 0; memRd = 0; issueRd = 0; aluData = 0; memData = 0;
    modelReset();
    doReset();

    // Single ALU write to r5
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("single_enable", {31'd0, wbEnable}, 32'd1);
    checkOutput("single_select", {27'd0, wbSelect}, 32'd5);
    checkOutput("single_data", wbData, 32'h1234);
    idle();
    checkOutput("single_count", {16'd0, wbCount}, 32'd1);

    // Tie alternation from reset: ALU, MEM, ALU, MEM
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd1, 32'hA000 + i, 1'b1, 5'd2, 32'hB000 + i, 1'b0, 5'd0);
      checkOutput("tie_select", {27'd0, wbSelect}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle();

    // Busy bit for r7: set, commit clears, re-issue on commit cycle keeps it set
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    checkOutput("busy7_set", {31'd0, busyMask[7]}, 32'd1);
    idle();
    idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    idle();
    checkOutput("busy7_cleared", {31'd0, busyMask[7]}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    checkOutput("busy7_set_wins", {31'd0, busyMask[7]}, 32'd1);

    // Write to r0 is consumed silently
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    checkOutput("r0_enable", {31'd0, wbEnable}, 32'd0);
    checkOutput("r0_busy0", {31'd0, busyMask[0]}, 32'd0);

    // Random traffic with frequent register collisions
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    // Reset during the write cycle drops the pending write at once
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    applyStimulus(1'b1, 5'd3, 32'hCAFE, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("midreset_enable", {31'd0, wbEnable}, 32'd0);
    checkOutput("midreset_busy", busyMask, 32'd0);
    checkOutput("midreset_count", {16'd0, wbCount}, 32'd0);
    checkOutput("midreset_alu_ready", {31'd0, aluReady}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midreset_hold_enable", {31'd0, wbEnable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    aluValid = 1'b0;

    // Counter wrap: 65535 back-to-back writes, then one more
    doReset();
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b1, 5'd1, i, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    end
    idle();
    checkOutput("count_full", {16'd0, wbCount}, 32'h0000FFFF);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    idle();
    checkOutput("count_wrap", {16'd0, wbCount}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
